codec_init_seq: RTL and testbench
=================================

Name: codec_init_seq

Overview:
- Upstream command sequencer for the bit-level I2C master driver.
- After a go pulse, walks a fixed table of audio-codec register writes (7-bit register address, 9-bit value, WM8731-style).
- Each entry becomes one I2C transaction: start, device-address byte, two payload bytes, stop.
- Drives the driver's start/stop/write/data inputs and consumes its cmd_done/cmd_status. Retries NACKed transactions and reports done/error to the audio top level.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit codec slave address; the transmitted byte is {DEV_ADDR, 1'b0}.
- N_ENTRIES, 10, number of table entries (1..16).
- MAX_RETRY, 3, NACK retries per entry before error (0..7).
- GAP_CYCLES, 8, idle sys_clk cycles after every command (1..255).
- TIMEOUT_CYCLES, 1023, maximum wait for cmd_done per command (1..1023).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle pulse; starts the sequence when idle
- busy  out  1  high from accepted go until done or error
- done  out  1  sticky high after all entries succeed; cleared by go
- error  out  1  sticky high on retry exhaustion or timeout; cleared by go
- err_entry  out  4  index of the failing entry, valid when error=1
- i2c_start  out  1  start command to the driver
- i2c_stop  out  1  stop command to the driver
- i2c_write  out  1  byte-write command to the driver
- i2c_data  out  8  byte to transmit, stable while i2c_write=1
- i2c_cmd_done  in  1  one-cycle completion pulse from the driver
- i2c_cmd_status  in  1  sampled ACK bit: 0=ACK, 1=NACK; valid with i2c_cmd_done after a write

Behaviour:
- Clocking and reset:
  - Single clock sys_clk; reset is asynchronous, active-low (sys_rst_n).
  - All outputs are registered.
  - Reset values: busy, done, error, i2c_start, i2c_stop, i2c_write = 0; i2c_data = 8'h00; err_entry = 0.
  - Internally: state = IDLE, entry = 0, retry = 0.
- Command handshake:
  - Exactly one of start/stop/write is asserted at a time.
  - The command is held high until i2c_cmd_done is sampled high.
  - It is deasserted on the following edge; i2c_data stays stable for that whole interval.
  - GAP then holds all commands low for GAP_CYCLES cycles.
- Timeout:
  - A counter starts when a command is asserted.
  - If TIMEOUT_CYCLES elapse without i2c_cmd_done: deassert the command, issue STOP, enter ERROR.
- States: IDLE -> START -> ADDR -> HI -> LO -> STOP -> NEXT, each command step followed by GAP.
  - IDLE: go -> entry=0, retry=0, clear done/error, busy=1, go to START. A go while busy is ignored.
  - START: pulse i2c_start via the handshake.
  - ADDR: write {DEV_ADDR,0}.
  - HI: write {reg[6:0], val[8]}.
  - LO: write val[7:0].
  - STOP: issue i2c_stop.
  - NACK (cmd_status=1) in ADDR, HI or LO: skip the remaining bytes, go to STOP.
    - If retry < MAX_RETRY: retry+1, then replay the same entry from START after GAP.
    - Else: err_entry=entry, go to ERROR.
  - NEXT: after a successful stop, retry=0 and entry+1.
    - If entry was N_ENTRIES-1: done=1, busy=0, go to IDLE.
  - ERROR: busy=0, error=1, return to IDLE. No wrap-around; entry never exceeds N_ENTRIES-1.
- Data selection:
  - Table entries are 16 bits: {reg[6:0], val[8:0]}.
  - Entry index is 4 bits.
  - i2c_data is taken from the table using the current entry.
- Reset mid-transaction:
  - All commands drop immediately.
  - The driver is left to its own reset; the sequencer restarts only on a new go.

Decomposition:
- Package codec_init_pkg holds:
  - the state enum;
  - the entry typedef {reg_addr[6:0], reg_val[8:0]};
  - the default DEV_ADDR;
  - codec register address constants (RESET=7'h0F, ACTIVE=7'h09, etc.).
- Sub-module codec_init_rom:
  - combinational 4-bit index -> 16-bit entry lookup holding the codec init values;
  - the entry at index 0 is reset (reg 7'h0F, val 9'h000);
  - entries beyond N_ENTRIES return 16'h0000.

Test Plan:
- Reset, no go -> all outputs 0 for 100 cycles, busy=0.
- go, slave model always ACKs, N_ENTRIES=2 -> sequence is start, 8'h34, 8'h1E, 8'h00, stop, then start, 8'h34, HI/LO of entry 1, stop; done=1 after final stop; exactly 2 stops.
- Entry 0 NACKs on HI once, then ACKs -> stop issued right after HI, transaction replayed from start with 8'h34; done=1; retry counter back to 0 for entry 1.
- Entry 1 NACKs on ADDR every time, MAX_RETRY=3 -> 4 attempts of entry 1; error=1, err_entry=1, done=0, busy=0.
- Driver never returns cmd_done on the first write, TIMEOUT_CYCLES=50 -> i2c_write drops at cycle 50, stop issued, error=1.
- sys_rst_n asserted low mid-LO byte -> i2c_write=0 immediately (asynchronously); after release, state is IDLE and a new go restarts from entry 0.

Source files
------------

// File: rtl/codec_init_pkg.sv
// Shared types and constants for the audio-codec init sequencer.
package codec_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_HI,
        ST_LO,
        ST_STOP,
        ST_GAP,
        ST_NEXT,
        ST_ERROR
    } state_e;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] reg_val;
    } entry_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    // WM8731-style register map
    localparam logic [6:0] REG_LLIN     = 7'h00;
    localparam logic [6:0] REG_RLIN     = 7'h01;
    localparam logic [6:0] REG_LHP      = 7'h02;
    localparam logic [6:0] REG_RHP      = 7'h03;
    localparam logic [6:0] REG_ANALOG   = 7'h04;
    localparam logic [6:0] REG_DIGITAL  = 7'h05;
    localparam logic [6:0] REG_POWER    = 7'h06;
    localparam logic [6:0] REG_IFACE    = 7'h07;
    localparam logic [6:0] REG_SAMPLING = 7'h08;
    localparam logic [6:0] REG_ACTIVE   = 7'h09;
    localparam logic [6:0] REG_RESET    = 7'h0F;

    function automatic entry_t mk_entry(input logic [6:0] a, input logic [8:0] v);
        entry_t e;
        e.reg_addr = a;
        e.reg_val  = v;
        return e;
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Codec init table: 4-bit index to {reg_addr, reg_val}; unused slots read as zero.
module codec_init_rom
    import codec_init_pkg::*;
#(
    parameter int N_ENTRIES = 10
) (
    input  logic [3:0] idx,
    output entry_t     entry
);

    always_comb begin
        entry = '0;
        case (idx)
            4'd0:    entry = mk_entry(REG_RESET,   9'h000);
            4'd1:    entry = mk_entry(REG_LLIN,    9'h017);
            4'd2:    entry = mk_entry(REG_RLIN,    9'h017);
            4'd3:    entry = mk_entry(REG_LHP,     9'h079);
            4'd4:    entry = mk_entry(REG_RHP,     9'h079);
            4'd5:    entry = mk_entry(REG_ANALOG,  9'h012);
            4'd6:    entry = mk_entry(REG_DIGITAL, 9'h000);
            4'd7:    entry = mk_entry(REG_POWER,   9'h000);
            4'd8:    entry = mk_entry(REG_IFACE,   9'h00A);
            4'd9:    entry = mk_entry(REG_ACTIVE,  9'h001);
            default: entry = '0;
        endcase
        if (32'(idx) >= N_ENTRIES) begin
            entry = '0;
        end
    end

endmodule

// File: rtl/codec_init_seq.sv
// Walks the codec init table, issuing one I2C write transaction per entry
// through the bit-level driver, with NACK retry and per-command timeout.
//
// state    | meaning
// IDLE     | waiting for go
// START    | i2c_start held until cmd_done
// ADDR     | device-address byte write
// HI       | {reg_addr, reg_val[8]} write
// LO       | reg_val[7:0] write
// STOP     | i2c_stop held until cmd_done
// GAP      | all commands low for GAP_CYCLES, then ret_q
// NEXT     | decide retry / next entry / done / error
// ERROR    | latch error and err_entry, back to IDLE
module codec_init_seq
    import codec_init_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = DEV_ADDR_DEFAULT,
    parameter int         N_ENTRIES      = 10,
    parameter int         MAX_RETRY      = 3,
    parameter int         GAP_CYCLES     = 8,
    parameter int         TIMEOUT_CYCLES = 1023
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       go,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_entry,
    output logic       i2c_start,
    output logic       i2c_stop,
    output logic       i2c_write,
    output logic [7:0] i2c_data,
    input  logic       i2c_cmd_done,
    input  logic       i2c_cmd_status
);

    localparam logic [3:0] LAST_ENTRY = 4'(N_ENTRIES - 1);
    localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
    localparam logic [9:0] TMO_LOAD   = 10'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    logic [3:0] entry_q, entry_d;
    logic [2:0] retry_q, retry_d;
    logic [7:0] gap_q, gap_d;
    logic [9:0] tmo_q, tmo_d;
    logic       nack_q, nack_d;
    logic       fail_q, fail_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [3:0] err_entry_q, err_entry_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       write_q, write_d;
    logic [7:0] data_q, data_d;

    entry_t rom_entry;
    logic   in_cmd;

    codec_init_rom #(.N_ENTRIES(N_ENTRIES)) u_rom (
        .idx   (entry_q),
        .entry (rom_entry)
    );

    assign in_cmd = state_q inside {ST_START, ST_ADDR, ST_HI, ST_LO, ST_STOP};

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        entry_d     = entry_q;
        retry_d     = retry_q;
        nack_d      = nack_q;
        fail_d      = fail_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_entry_d = err_entry_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    entry_d = '0;
                    retry_d = '0;
                    nack_d  = 1'b0;
                    fail_d  = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START, ST_ADDR, ST_HI, ST_LO, ST_STOP: begin
                if (i2c_cmd_done) begin
                    state_d = ST_GAP;
                    case (state_q)
                        ST_START: ret_d = ST_ADDR;
                        ST_ADDR:  ret_d = i2c_cmd_status ? ST_STOP : ST_HI;
                        ST_HI:    ret_d = i2c_cmd_status ? ST_STOP : ST_LO;
                        ST_LO:    ret_d = ST_STOP;
                        default:  ret_d = ST_NEXT;
                    endcase
                    if (i2c_cmd_status && state_q inside {ST_ADDR, ST_HI, ST_LO}) begin
                        nack_d = 1'b1;
                    end
                end else if (tmo_q == '0) begin
                    // A stalled stop cannot be closed with another stop.
                    if (state_q == ST_STOP) begin
                        state_d = ST_ERROR;
                    end else begin
                        fail_d  = 1'b1;
                        ret_d   = ST_STOP;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ret_q;
                end
            end
            ST_NEXT: begin
                if (fail_q) begin
                    state_d = ST_ERROR;
                end else if (nack_q) begin
                    nack_d = 1'b0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    retry_d = '0;
                    if (entry_q == LAST_ENTRY) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        entry_d = entry_q + 4'd1;
                        state_d = ST_START;
                    end
                end
            end
            ST_ERROR: begin
                busy_d      = 1'b0;
                error_d     = 1'b1;
                err_entry_d = entry_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d inside {ST_START, ST_ADDR, ST_HI, ST_LO, ST_STOP} && state_d != state_q) begin
            tmo_d = TMO_LOAD;
        end else if (in_cmd && tmo_q != '0) begin
            tmo_d = tmo_q - 10'd1;
        end

        if (state_d == ST_GAP && state_q != ST_GAP) begin
            gap_d = GAP_LOAD;
        end else if (state_q == ST_GAP && gap_q != '0) begin
            gap_d = gap_q - 8'd1;
        end

        start_d = (state_d == ST_START);
        stop_d  = (state_d == ST_STOP);
        write_d = state_d inside {ST_ADDR, ST_HI, ST_LO};
        case (state_d)
            ST_ADDR: data_d = {DEV_ADDR, 1'b0};
            ST_HI:   data_d = {rom_entry.reg_addr, rom_entry.reg_val[8]};
            ST_LO:   data_d = rom_entry.reg_val[7:0];
            default: data_d = data_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            entry_q     <= '0;
            retry_q     <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            nack_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_entry_q <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            write_q     <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            entry_q     <= entry_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            nack_q      <= nack_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_entry_q <= err_entry_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            write_q     <= write_d;
            data_q      <= data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_entry = err_entry_q;
    assign i2c_start = start_q;
    assign i2c_stop  = stop_q;
    assign i2c_write = write_q;
    assign i2c_data  = data_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: randomized-latency I2C driver model, NACK plans,
// and a transaction-level reference of the expected command stream.
module tb_codec_init_seq;

    localparam int N    = 2;
    localparam int MAXR = 3;
    localparam int GAP  = 3;
    localparam int TMO  = 50;
    localparam int DEV  = 'h1A;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       go = 1'b0;
    logic       busy, done, error;
    logic [3:0] err_entry;
    logic       i2c_start, i2c_stop, i2c_write;
    logic [7:0] i2c_data;
    logic       i2c_cmd_done = 1'b0;
    logic       i2c_cmd_status = 1'b0;

    int vec = 0;
    int miss = 0;

    int exp_q[$];
    int obs_q[$];
    bit stat_q[$];
    int exp_done, exp_err, exp_err_entry;
    int plan[N][MAXR+1];
    bit hang_en = 1'b0;
    logic [7:0] hang_byte = 8'h00;

    int tbl_reg[N] = '{'h0F, 'h00};
    int tbl_val[N] = '{'h000, 'h017};

    codec_init_seq #(
        .DEV_ADDR       (7'h1A),
        .N_ENTRIES      (N),
        .MAX_RETRY      (MAXR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .go             (go),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_entry      (err_entry),
        .i2c_start      (i2c_start),
        .i2c_stop       (i2c_stop),
        .i2c_write      (i2c_write),
        .i2c_data       (i2c_data),
        .i2c_cmd_done   (i2c_cmd_done),
        .i2c_cmd_status (i2c_cmd_status)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge sys_clk);
        go = 1'b0;
    endtask

    task automatic clear_plan();
        for (int e = 0; e < N; e++)
            for (int a = 0; a <= MAXR; a++)
                plan[e][a] = 0;
    endtask

    // plan[e][a]: 0 = attempt a of entry e fully ACKed, 1/2/3 = NACK on addr/hi/lo byte
    task automatic build_model();
        int attempt;
        int p;
        bit ok;
        int bytes[3];
        exp_q.delete();
        stat_q.delete();
        exp_done = 0;
        exp_err = 0;
        exp_err_entry = 0;
        for (int e = 0; e < N; e++) begin
            attempt = 0;
            ok = 1'b0;
            while (!ok) begin
                p = plan[e][attempt];
                bytes[0] = DEV * 2;
                bytes[1] = tbl_reg[e] * 2 + tbl_val[e] / 256;
                bytes[2] = tbl_val[e] % 256;
                exp_q.push_back('h100);
                for (int b = 0; b < 3; b++) begin
                    exp_q.push_back('h200 + bytes[b]);
                    stat_q.push_back(p == b + 1);
                    if (p == b + 1) break;
                end
                exp_q.push_back('h300);
                if (p == 0) ok = 1'b1;
                else if (attempt < MAXR) attempt++;
                else begin
                    exp_err = 1;
                    exp_err_entry = e;
                    return;
                end
            end
        end
        exp_done = 1;
    endtask

    task automatic start_run(input string tag);
        int n;
        obs_q.delete();
        pulse_go();
        n = 0;
        while (!busy && n < 10) begin tick(1); n++; end
        check({tag, "_busy_rise"}, busy, 1);
    endtask

    task automatic finish_run(input string tag);
        int n;
        int got;
        n = 0;
        while (busy && n < 20000) begin tick(1); n++; end
        check({tag, "_busy_fall"}, busy, 0);
        tick(GAP + 6);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, exp_err);
        if (exp_err != 0) check({tag, "_err_entry"}, err_entry, exp_err_entry);
        check({tag, "_ncmds"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'hFFFF;
            check($sformatf("%s_cmd%0d", tag, i), got, exp_q[i]);
        end
        check({tag, "_cmds_idle"}, {i2c_start, i2c_stop, i2c_write}, 0);
    endtask

    // Monitor: records each command as it is raised and checks handshake invariants.
    initial begin
        logic ps, pp, pw;
        logic [7:0] pd;
        ps = 0; pp = 0; pw = 0; pd = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                if (i2c_start && !ps) obs_q.push_back('h100);
                if (i2c_write && !pw) obs_q.push_back('h200 + int'(i2c_data));
                if (i2c_stop && !pp) obs_q.push_back('h300);
                if (i2c_write && pw) check("data_stable", i2c_data, pd);
                if (i2c_start || i2c_stop || i2c_write)
                    check("cmd_onehot", 32'(i2c_start) + 32'(i2c_stop) + 32'(i2c_write), 1);
            end
            ps = i2c_start; pp = i2c_stop; pw = i2c_write; pd = i2c_data;
        end
    end

    // Driver model: random completion latency, write status from stat_q.
    initial begin
        int lat;
        int n;
        bit is_wr;
        bit st;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && (i2c_start || i2c_stop || i2c_write)) begin
                is_wr = i2c_write;
                if (is_wr && hang_en && i2c_data == hang_byte) begin
                    hang_en = 1'b0;
                    n = 0;
                    while (i2c_write && n < 500) begin @(negedge sys_clk); n++; end
                end else begin
                    lat = $urandom_range(0, 3);
                    repeat (lat) @(negedge sys_clk);
                    st = 1'b0;
                    if (is_wr && stat_q.size() > 0) st = stat_q.pop_front();
                    i2c_cmd_done = 1'b1;
                    i2c_cmd_status = st;
                    @(negedge sys_clk);
                    i2c_cmd_done = 1'b0;
                    i2c_cmd_status = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(3);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("reset_idle", {busy, done, error, err_entry, i2c_start, i2c_stop, i2c_write, i2c_data}, 0);
        end

        // All entries ACK; a go while busy must be ignored.
        clear_plan();
        build_model();
        start_run("all_ack");
        tick(30);
        pulse_go();
        finish_run("all_ack");

        // Entry 0 NACKs HI once; entry 1 uses every retry and succeeds on the last.
        clear_plan();
        plan[0][0] = 2;
        plan[1][0] = 1; plan[1][1] = 2; plan[1][2] = 3;
        build_model();
        start_run("nack_hi");
        finish_run("nack_hi");

        // Entry 1 NACKs the address on every attempt.
        clear_plan();
        for (int a = 0; a <= MAXR; a++) plan[1][a] = 1;
        build_model();
        start_run("exhaust");
        finish_run("exhaust");

        for (int r = 0; r < 8; r++) begin
            for (int e = 0; e < N; e++)
                for (int a = 0; a <= MAXR; a++)
                    plan[e][a] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            build_model();
            start_run($sformatf("rand%0d", r));
            finish_run($sformatf("rand%0d", r));
        end

        // Driver never completes the first write.
        clear_plan();
        build_model();
        exp_q.delete();
        exp_q.push_back('h100);
        exp_q.push_back('h200 + DEV * 2);
        exp_q.push_back('h300);
        exp_done = 0; exp_err = 1; exp_err_entry = 0;
        hang_en = 1'b1;
        hang_byte = 8'(DEV * 2);
        start_run("timeout");
        n = 0;
        while (!i2c_write && n < 300) begin tick(1); n++; end
        check("timeout_write_seen", i2c_write, 1);
        n = 0;
        while (i2c_write && n < 300) begin tick(1); n++; end
        check("timeout_write_cycles", n, TMO);
        finish_run("timeout");

        // Reset asserted while the LO byte of entry 0 is outstanding.
        clear_plan();
        build_model();
        hang_en = 1'b1;
        hang_byte = 8'h00;
        start_run("rst_mid");
        n = 0;
        while (!(i2c_write && i2c_data == 8'h00) && n < 300) begin tick(1); n++; end
        check("rst_mid_lo_seen", {i2c_write, i2c_data}, 9'h100);
        tick(2);
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_write_drop", {i2c_start, i2c_stop, i2c_write, busy}, 0);
        tick(3);
        sys_rst_n = 1'b1;
        obs_q.delete();
        tick(20);
        check("rst_mid_quiet", obs_q.size(), 0);
        check("rst_mid_flags", {busy, done, error}, 0);
        hang_en = 1'b0;
        build_model();
        start_run("rst_restart");
        finish_run("rst_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
